// File: rtl/game_pkg.sv
// game_pkg
//   Shared constants for the game video pipeline. Holds the default
//   1024x768@60 raster timing. vga_timing_gen uses these values as its
//   parameter defaults, so a plain instantiation yields the standard mode.
//   There are no ports; importers use the localparams below.
package game_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_ACTIVE     = 1024;
  localparam int H_SYNC_START = 1048;
  localparam int H_SYNC_END   = 1184;
  localparam int H_TOTAL      = 1344;

  // Vertical timing, in lines
  localparam int V_ACTIVE     = 768;
  localparam int V_SYNC_START = 771;
  localparam int V_SYNC_END   = 777;
  localparam int V_TOTAL      = 806;

  // 1 = syncs active-high, 0 = active-low
  localparam bit SYNC_POL     = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: a wrapping counter with registered sync and blanking
//   decode. Instantiated once for the horizontal axis and once for the
//   vertical axis.
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset
//     en         : advance the counter on this clock edge
//     count      : current position, 0 .. TOTAL-1
//     sync       : SYNC_POL while SYNC_START <= count < SYNC_END, else ~SYNC_POL
//     blnk       : high while count >= ACTIVE
//     wrap       : combinational, high when en is set and count is at TOTAL-1
//                  (so the next edge returns the counter to 0)
module vga_axis_counter
  import game_pkg::*;
#(
  parameter int  TOTAL      = H_TOTAL,
  parameter int  ACTIVE     = H_ACTIVE,
  parameter int  SYNC_START = H_SYNC_START,
  parameter int  SYNC_END   = H_SYNC_END,
  parameter bit  SYNC_POL   = 1'b1,
  localparam int W          = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         blnk,
  output logic         wrap
);

  // Reject timings where the sync pulse does not sit inside the blanking
  // interval. Catching this at elaboration is cheaper than in the lab.
  if (!(ACTIVE < SYNC_START && SYNC_START < SYNC_END && SYNC_END <= TOTAL)) begin : g_bad_timing
    $error("vga_axis_counter: need ACTIVE < SYNC_START < SYNC_END <= TOTAL");
  end

  // SYNC_END may equal TOTAL, which need not fit in W bits, so every
  // comparison is done one bit wider.
  localparam logic [W:0] LAST_X  = (W+1)'(TOTAL - 1);
  localparam logic [W:0] ACT_X   = (W+1)'(ACTIVE);
  localparam logic [W:0] SSTRT_X = (W+1)'(SYNC_START);
  localparam logic [W:0] SEND_X  = (W+1)'(SYNC_END);

  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;
  logic         blnk_q, blnk_d;
  logic [W:0]   count_ext;

  // The decode looks at the next count, not the current one. Registering it
  // alongside the counter keeps sync and blank aligned with count.
  always_comb begin
    wrap      = en && ({1'b0, count_q} == LAST_X);
    count_d   = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    count_ext = {1'b0, count_d};
    blnk_d    = (count_ext >= ACT_X);
    sync_d    = (count_ext >= SSTRT_X && count_ext < SEND_X) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sync_q  <= ~SYNC_POL;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;
  assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator at the head of the video pipeline.
//   Produces pixel and line counters, syncs, blanking and line/frame strobes
//   for any VGA mode. Counting is gated by pix_en, so a fast system clock can
//   drive a slower pixel rate.
//   Ports:
//     clk, rst_n  : clock and asynchronous active-low reset
//     pix_en      : pixel enable; counters advance only while high
//     hcount      : current pixel column
//     vcount      : current line
//     hsync/vsync : syncs, active level set by SYNC_POL
//     hblnk/vblnk : high outside the visible area on each axis
//     line_start  : one-clk pulse when hcount returns to 0
//     frame_start : one-clk pulse when (hcount, vcount) returns to (0, 0)
//   Optional (macro VGA_TIMING_LINE_MATCH_EN):
//     line_cmp    : line number to watch for
//     line_match  : one-clk pulse with line_start when the new vcount == line_cmp
module vga_timing_gen
  import game_pkg::*;
#(
  parameter int  H_ACTIVE     = game_pkg::H_ACTIVE,
  parameter int  H_SYNC_START = game_pkg::H_SYNC_START,
  parameter int  H_SYNC_END   = game_pkg::H_SYNC_END,
  parameter int  H_TOTAL      = game_pkg::H_TOTAL,
  parameter int  V_ACTIVE     = game_pkg::V_ACTIVE,
  parameter int  V_SYNC_START = game_pkg::V_SYNC_START,
  parameter int  V_SYNC_END   = game_pkg::V_SYNC_END,
  parameter int  V_TOTAL      = game_pkg::V_TOTAL,
  parameter bit  SYNC_POL     = game_pkg::SYNC_POL,
  localparam int HW           = $clog2(H_TOTAL),
  localparam int VW           = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_LINE_MATCH_EN
  ,
  input  logic [VW-1:0] line_cmp,
  output logic          line_match
`endif
);

  logic h_wrap;
  logic v_wrap;
  logic v_en;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .count (hcount),
    .sync  (hsync),
    .blnk  (hblnk),
    .wrap  (h_wrap)
  );

  // The line counter steps only on the pixel edge that wraps the column.
  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_en),
    .count (vcount),
    .sync  (vsync),
    .blnk  (vblnk),
    .wrap  (v_wrap)
  );

  // Strobes are registered from the wrap conditions, so they are high in the
  // cycle where the new position is presented. h_wrap already includes
  // pix_en, which keeps both strobes low on disabled cycles and on reset
  // release.
  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_LINE_MATCH_EN
  logic [VW-1:0] v_next;
  logic          line_match_q, line_match_d;

  // Compare against the line about to be entered, so the match pulse lines
  // up with line_start.
  always_comb begin
    v_next       = v_wrap ? '0 : vcount + 1'b1;
    line_match_d = h_wrap && (v_next == line_cmp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_match_q <= 1'b0;
    end else begin
      line_match_q <= line_match_d;
    end
  end

  assign line_match = line_match_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. A small SYNC_POL=0 instance is walked
//   through a table of hand-computed vectors and a few multi-cycle corner
//   cases; a default-parameter instance checks one full line with pix_en
//   held high and with pix_en toggling.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance: H 8/9/11/12, V 4/5/6/7, active-low syncs
  logic       rst_n_s, pix_en_s;
  logic [3:0] hcount_s;
  logic [2:0] vcount_s;
  logic       hsync_s, vsync_s, hblnk_s, vblnk_s, ls_s, fs_s;

  // default instance: 1024x768
  logic        rst_n_b, pix_en_b;
  logic [10:0] hcount_b;
  logic [9:0]  vcount_b;
  logic        hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b;

`ifdef VGA_TIMING_LINE_MATCH_EN
  logic [2:0] line_cmp_s;
  logic       lm_s;
  logic [9:0] line_cmp_b;
  logic       lm_b;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_SYNC_START(9), .H_SYNC_END(11), .H_TOTAL(12),
    .V_ACTIVE(4), .V_SYNC_START(5), .V_SYNC_END(6), .V_TOTAL(7),
    .SYNC_POL(1'b0)
  ) dut_small (
    .clk(clk), .rst_n(rst_n_s), .pix_en(pix_en_s),
    .hcount(hcount_s), .vcount(vcount_s),
    .hsync(hsync_s), .vsync(vsync_s), .hblnk(hblnk_s), .vblnk(vblnk_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_LINE_MATCH_EN
    , .line_cmp(line_cmp_s), .line_match(lm_s)
`endif
  );

  vga_timing_gen dut_big (
    .clk(clk), .rst_n(rst_n_b), .pix_en(pix_en_b),
    .hcount(hcount_b), .vcount(vcount_b),
    .hsync(hsync_b), .vsync(vsync_b), .hblnk(hblnk_b), .vblnk(vblnk_b),
    .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_LINE_MATCH_EN
    , .line_cmp(line_cmp_b), .line_match(lm_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int steps;
    bit en;
    int h;
    int v;
    bit hs, vs, hb, vb, ls, fs;
  } vec_t;

  vec_t vecs[17];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Hold pix_en on the small instance for a number of clock edges, then
  // settle just after the last edge.
  task automatic applyStimulus(input int steps, input bit en);
    pix_en_s = en;
    repeat (steps) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int steps, bit en, int h, int v,
                              bit hs, bit vs, bit hb, bit vb, bit ls, bit fs);
    vec_t r;
    r.steps = steps; r.en = en; r.h = h; r.v = v;
    r.hs = hs; r.vs = vs; r.hb = hb; r.vb = vb; r.ls = ls; r.fs = fs;
    return r;
  endfunction

  initial begin
    int fs_cyc[$];
    int ls_cyc[$];
    int vs_cnt, vb_cnt, hs_cnt, in_frame;
    int hs_hi, hb_hi, ls_n, skew, viol, n_en;
    int mh;

    // steps, en, h, v, hsync, vsync, hblnk, vblnk, line_start, frame_start
    vecs[0]  = mk( 0, 1,  0, 0, 1, 1, 0, 0, 0, 0);
    vecs[1]  = mk( 8, 1,  8, 0, 1, 1, 1, 0, 0, 0);
    vecs[2]  = mk( 1, 1,  9, 0, 0, 1, 1, 0, 0, 0);
    vecs[3]  = mk( 1, 1, 10, 0, 0, 1, 1, 0, 0, 0);
    vecs[4]  = mk( 1, 1, 11, 0, 1, 1, 1, 0, 0, 0);
    vecs[5]  = mk( 1, 1,  0, 1, 1, 1, 0, 0, 1, 0);
    vecs[6]  = mk( 1, 1,  1, 1, 1, 1, 0, 0, 0, 0);
    vecs[7]  = mk(35, 1,  0, 4, 1, 1, 0, 1, 1, 0);
    vecs[8]  = mk(12, 1,  0, 5, 1, 0, 0, 1, 1, 0);
    vecs[9]  = mk(12, 1,  0, 6, 1, 1, 0, 1, 1, 0);
    vecs[10] = mk(11, 1, 11, 6, 1, 1, 1, 1, 0, 0);
    vecs[11] = mk( 1, 1,  0, 0, 1, 1, 0, 0, 1, 1);
    vecs[12] = mk( 1, 1,  1, 0, 1, 1, 0, 0, 0, 0);
    vecs[13] = mk(10, 1, 11, 0, 1, 1, 1, 0, 0, 0);
    vecs[14] = mk( 2, 0, 11, 0, 1, 1, 1, 0, 0, 0);
    vecs[15] = mk( 1, 1,  0, 1, 1, 1, 0, 0, 1, 0);
    vecs[16] = mk( 1, 0,  0, 1, 1, 1, 0, 0, 0, 0);

    rst_n_s = 1'b0; rst_n_b = 1'b0; pix_en_s = 1'b0; pix_en_b = 1'b0;
`ifdef VGA_TIMING_LINE_MATCH_EN
    line_cmp_s = 3'd3; line_cmp_b = '0;
`endif
    #23;
    checkOutput("big reset hcount", int'(hcount_b), 0);
    checkOutput("big reset vcount", int'(vcount_b), 0);
    checkOutput("big reset hsync",  int'(hsync_b), 0);
    checkOutput("big reset vsync",  int'(vsync_b), 0);
    checkOutput("big reset hblnk",  int'(hblnk_b), 0);
    checkOutput("big reset strobes", int'({ls_b, fs_b}), 0);
    @(negedge clk);
    rst_n_s = 1'b1; rst_n_b = 1'b1;

    // table walk on the small instance
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].steps, vecs[i].en);
      checkOutput($sformatf("vec%0d hcount", i), int'(hcount_s), vecs[i].h);
      checkOutput($sformatf("vec%0d vcount", i), int'(vcount_s), vecs[i].v);
      checkOutput($sformatf("vec%0d hsync", i),  int'(hsync_s),  int'(vecs[i].hs));
      checkOutput($sformatf("vec%0d vsync", i),  int'(vsync_s),  int'(vecs[i].vs));
      checkOutput($sformatf("vec%0d hblnk", i),  int'(hblnk_s),  int'(vecs[i].hb));
      checkOutput($sformatf("vec%0d vblnk", i),  int'(vblnk_s),  int'(vecs[i].vb));
      checkOutput($sformatf("vec%0d line_start", i),  int'(ls_s), int'(vecs[i].ls));
      checkOutput($sformatf("vec%0d frame_start", i), int'(fs_s), int'(vecs[i].fs));
    end

    // small instance: frame period and per-frame sync/blank counts
    vs_cnt = 0; vb_cnt = 0; hs_cnt = 0; in_frame = 0;
    pix_en_s = 1'b1;
    for (int c = 1; c <= 200 && fs_cyc.size() < 2; c++) begin
      @(posedge clk); #1;
      if (fs_s) begin
        fs_cyc.push_back(c);
        in_frame = (fs_cyc.size() == 1) ? 1 : 0;
      end
      if (in_frame != 0) begin
        if (!vsync_s) vs_cnt++;
        if (vblnk_s)  vb_cnt++;
        if (!hsync_s) hs_cnt++;
      end
    end
    checkOutput("small frame_start seen twice", fs_cyc.size(), 2);
    if (fs_cyc.size() == 2)
      checkOutput("small frame_start spacing", fs_cyc[1] - fs_cyc[0], 84);
    checkOutput("small vsync low pixels/frame", vs_cnt, 12);
    checkOutput("small vblnk pixels/frame", vb_cnt, 36);
    checkOutput("small hsync low pixels/frame", hs_cnt, 14);

    // small instance: reset dropped mid-frame at (5,2)
    rst_n_s = 1'b0; #2;
    @(negedge clk); rst_n_s = 1'b1;
    applyStimulus(29, 1'b1);
    checkOutput("pre-reset hcount", int'(hcount_s), 5);
    checkOutput("pre-reset vcount", int'(vcount_s), 2);
    rst_n_s = 1'b0;
    #1;
    checkOutput("mid reset hcount", int'(hcount_s), 0);
    checkOutput("mid reset vcount", int'(vcount_s), 0);
    checkOutput("mid reset syncs",  int'({hsync_s, vsync_s}), 3);
    checkOutput("mid reset blanks", int'({hblnk_s, vblnk_s}), 0);
    checkOutput("mid reset strobes", int'({ls_s, fs_s}), 0);
    @(negedge clk); rst_n_s = 1'b1;
    @(posedge clk); #1;
    checkOutput("post reset hcount", int'(hcount_s), 1);
    checkOutput("post reset strobes", int'({ls_s, fs_s}), 0);

`ifdef VGA_TIMING_LINE_MATCH_EN
    // line_match on line 3, one pulse per frame, together with line_start
    rst_n_s = 1'b0; #2;
    @(negedge clk); rst_n_s = 1'b1;
    checkOutput("line_match reset", int'(lm_s), 0);
    viol = 0; ls_n = 0;
    for (int c = 1; c <= 84; c++) begin
      @(posedge clk); #1;
      if (lm_s) begin
        ls_n++;
        if (!(ls_s && vcount_s == 3'd3 && hcount_s == 4'd0)) viol++;
      end
    end
    checkOutput("line_match pulses/frame", ls_n, 1);
    checkOutput("line_match coincidence errors", viol, 0);
`endif
    pix_en_s = 1'b0;

    // default instance: one line with pix_en high
    rst_n_b = 1'b0; #2;
    @(negedge clk); rst_n_b = 1'b1;
    pix_en_b = 1'b1;
    hs_hi = 0; hb_hi = 0; ls_n = 0; skew = 0;
    for (int c = 1; c <= 1344; c++) begin
      @(posedge clk); #1;
      mh = c % 1344;
      if (int'(hcount_b) != mh) skew++;
      if (hsync_b != (mh >= 1048 && mh < 1184)) skew++;
      if (hblnk_b != (mh >= 1024)) skew++;
      if (hsync_b) hs_hi++;
      if (hblnk_b) hb_hi++;
      if (ls_b) ls_n++;
    end
    checkOutput("big line hcount", int'(hcount_b), 0);
    checkOutput("big line vcount", int'(vcount_b), 1);
    checkOutput("big line_start on wrap", int'(ls_b), 1);
    checkOutput("big line_start count", ls_n, 1);
    checkOutput("big hsync high cycles", hs_hi, 136);
    checkOutput("big hblnk high cycles", hb_hi, 320);
    checkOutput("big hsync/hblnk skew errors", skew, 0);
    checkOutput("big vsync inactive on line 1", int'(vsync_b), 0);

    // default instance: pix_en toggling 1,0,1,0
    rst_n_b = 1'b0; #2;
    @(negedge clk); rst_n_b = 1'b1;
    viol = 0; skew = 0; n_en = 0;
    for (int c = 1; c <= 5400; c++) begin
      pix_en_b = (c % 2 == 1);
      @(posedge clk); #1;
      if (pix_en_b) n_en++;
      if (int'(hcount_b) != n_en % 1344) skew++;
      if (ls_b) begin
        ls_cyc.push_back(c);
        if (!pix_en_b) viol++;
      end
    end
    pix_en_b = 1'b0;
    checkOutput("toggle line_start count", ls_cyc.size(), 2);
    if (ls_cyc.size() >= 1) checkOutput("toggle first line_start cycle", ls_cyc[0], 2687);
    if (ls_cyc.size() >= 2) checkOutput("toggle line period", ls_cyc[1] - ls_cyc[0], 2688);
    checkOutput("toggle strobe while pix_en=0", viol, 0);
    checkOutput("toggle hcount tracking errors", skew, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
